nibble_serial_adder_amisha: RTL and testbench



---
 rtl/adder_pkg_amisha.sv | 20 ++
 rtl/adder_carry_local_par_Amisha.sv | 32 +++
 rtl/nibble_serial_adder_amisha.sv | 121 ++++++++++++
 tb/tb_nibble_serial_adder_amisha.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg_amisha.sv
// Shared types and helpers for the nibble-serial adder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package adder_pkg_amisha;

  localparam int NIBBLE_W = 4;

  typedef enum logic {IDLE, RUN} state_t;

  // Ceiling log2, clamped to 1 so a slice index always has at least one bit.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < n) r = r + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/adder_carry_local_par_Amisha.sv
// 4-bit carry-lookahead adder slice; all carries from generate/propagate terms.
// Latency: combinational.
// Backpressure: none.
module adder_carry_local_par_Amisha
  import adder_pkg_amisha::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] sum,
  output logic                cout
);

  logic [NIBBLE_W-1:0] g;
  logic [NIBBLE_W-1:0] p;
  logic [NIBBLE_W:0]   c;

  assign g = a & b;
  assign p = a ^ b;

  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & cin);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & cin);

  assign sum  = p ^ c[NIBBLE_W-1:0];
  assign cout = c[NIBBLE_W];

endmodule

// File: rtl/nibble_serial_adder_amisha.sv
// WIDTH-bit adder streaming one nibble per clock through a single CLA slice.
// Latency: done pulses NSLICE cycles after start is sampled; back-to-back via start in done cycle.
// Backpressure: start ignored while busy; SERIAL_ADDER_SUBTRACT_EN adds sub_amisha (a-b).
module nibble_serial_adder_amisha
  import adder_pkg_amisha::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk_amisha,
  input  logic             reset_amisha,
  input  logic             start_amisha,
  input  logic [WIDTH-1:0] a_amisha,
  input  logic [WIDTH-1:0] b_amisha,
  input  logic             cin_amisha,
`ifdef SERIAL_ADDER_SUBTRACT_EN
  input  logic             sub_amisha,
`endif
  output logic             busy_amisha,
  output logic             done_amisha,
  output logic [WIDTH-1:0] sum_amisha,
  output logic             cout_amisha,
  output logic             ovf_amisha
);

  localparam int NSLICE = WIDTH / NIBBLE_W;
  localparam int IDXW   = clog2(NSLICE);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSLICE - 1);

  state_t              state;
  state_t              state_nxt;
  logic [IDXW-1:0]     idx;
  logic                carry;
  logic [WIDTH-1:0]    a_r;
  logic [WIDTH-1:0]    b_r;
  logic [WIDTH-1:0]    acc;
  logic [WIDTH-1:0]    acc_nxt;
  logic [NIBBLE_W-1:0] slice_a;
  logic [NIBBLE_W-1:0] slice_b;
  logic [NIBBLE_W-1:0] slice_sum;
  logic                slice_cout;
  logic                sub_sel;
  logic                accept;
  logic                last_slice;

`ifdef SERIAL_ADDER_SUBTRACT_EN
  assign sub_sel = sub_amisha;
`else
  assign sub_sel = 1'b0;
`endif

  assign accept      = (state == IDLE) && start_amisha;
  assign last_slice  = (state == RUN) && (idx == LAST_IDX);
  assign busy_amisha = (state == RUN);

  always_comb begin
    slice_a = a_r[int'(idx)*NIBBLE_W +: NIBBLE_W];
    slice_b = b_r[int'(idx)*NIBBLE_W +: NIBBLE_W];
  end

  adder_carry_local_par_Amisha u_slice (
    .a    (slice_a),
    .b    (slice_b),
    .cin  (carry),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  // Accumulator with the current nibble merged in; on the last slice this is the full result.
  always_comb begin
    acc_nxt = acc;
    acc_nxt[int'(idx)*NIBBLE_W +: NIBBLE_W] = slice_sum;
  end

  always_ff @(posedge clk_amisha) begin
    if (reset_amisha) state <= IDLE;
    else              state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_amisha) state_nxt = RUN;
      RUN:     if (idx == LAST_IDX) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_amisha) begin
    if (reset_amisha) begin
      idx         <= '0;
      carry       <= 1'b0;
      a_r         <= '0;
      b_r         <= '0;
      acc         <= '0;
      done_amisha <= 1'b0;
      sum_amisha  <= '0;
      cout_amisha <= 1'b0;
      ovf_amisha  <= 1'b0;
    end else begin
      done_amisha <= 1'b0;
      if (accept) begin
        a_r   <= a_amisha;
        b_r   <= sub_sel ? ~b_amisha : b_amisha;
        carry <= sub_sel ? 1'b1 : cin_amisha;
        idx   <= '0;
      end else if (state == RUN) begin
        acc   <= acc_nxt;
        carry <= slice_cout;
        idx   <= idx + 1'b1;
        if (last_slice) begin
          sum_amisha  <= acc_nxt;
          cout_amisha <= slice_cout;
          // Carry into the MSB xor carry out of it gives signed overflow.
          ovf_amisha  <= a_r[WIDTH-1] ^ b_r[WIDTH-1] ^ acc_nxt[WIDTH-1] ^ slice_cout;
          done_amisha <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_nibble_serial_adder_amisha.sv
// Directed-vector scoreboard bench for nibble_serial_adder_amisha (WIDTH=16).
// Expected results are hand-computed and queued at issue; a monitor checks each done pulse.
module tb_nibble_serial_adder_amisha;

  typedef struct {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
    int          cyc;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        sub;
  logic        busy;
  logic        done;
  logic [15:0] sum;
  logic        cout;
  logic        ovf;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  logic prev_done = 1'b0;

  nibble_serial_adder_amisha #(.WIDTH(16)) dut (
    .clk_amisha   (clk),
    .reset_amisha (reset),
    .start_amisha (start),
    .a_amisha     (a),
    .b_amisha     (b),
    .cin_amisha   (cin),
`ifdef SERIAL_ADDER_SUBTRACT_EN
    .sub_amisha   (sub),
`endif
    .busy_amisha  (busy),
    .done_amisha  (done),
    .sum_amisha   (sum),
    .cout_amisha  (cout),
    .ovf_amisha   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Monitor: pops one expectation per done pulse and checks result, latency and pulse width.
  always @(negedge clk) begin
    exp_t e;
    if (prev_done) begin
      checks++;
      if (done) begin
        errors++;
        $display("FAIL done_width: done=%0b two cycles in a row, required single-cycle pulse", done);
      end
    end
    prev_done = done;
    if (done) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: done=1 at cycle %0d with no operation outstanding", cyc);
      end else begin
        e = q.pop_front();
        checks++;
        if ({sum, cout, ovf} !== {e.sum, e.cout, e.ovf}) begin
          errors++;
          $display("FAIL result: sum=%h cout=%0b ovf=%0b, required sum=%h cout=%0b ovf=%0b",
                   sum, cout, ovf, e.sum, e.cout, e.ovf);
        end
        checks++;
        if (cyc != e.cyc) begin
          errors++;
          $display("FAIL latency: done at cycle %0d, required cycle %0d", cyc, e.cyc);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Called right after a negedge; returns at the negedge after the capture edge.
  task automatic start_op(input logic [15:0] ta, input logic [15:0] tb_, input logic tcin,
                          input logic tsub, input logic [15:0] xs, input logic xc, input logic xo);
    exp_t e;
    start = 1'b1;
    a     = ta;
    b     = tb_;
    cin   = tcin;
    sub   = tsub;
    e.sum  = xs;
    e.cout = xc;
    e.ovf  = xo;
    e.cyc  = cyc + 1 + 4;
    q.push_back(e);
    @(negedge clk);
    start = 1'b0;
    a     = 16'hDEAD;
    b     = 16'hBEEF;
    cin   = 1'b1;
    sub   = ~tsub;
  endtask

  task automatic wait_done();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL timeout: done=0 after 20 cycles, required done=1");
    end
  endtask

  task automatic op(input logic [15:0] ta, input logic [15:0] tb_, input logic tcin,
                    input logic tsub, input logic [15:0] xs, input logic xc, input logic xo);
    start_op(ta, tb_, tcin, tsub, xs, xc, xo);
    wait_done();
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    cin   = 1'b0;
    sub   = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {11'd0, busy, done, cout, ovf, sum}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_after_reset", {30'd0, busy, done}, 32'd0);

    op(16'h0007, 16'h0000, 1'b0, 1'b0, 16'h0007, 1'b0, 1'b0);
    op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    op(16'h1234, 16'h0000, 1'b1, 1'b0, 16'h1235, 1'b0, 1'b0);

    // Start while busy must be ignored.
    start_op(16'h1111, 16'h2222, 1'b0, 1'b0, 16'h3333, 1'b0, 1'b0);
    chk("busy_in_run", {31'd0, busy}, 32'd1);
    start = 1'b1;
    a     = 16'hAAAA;
    b     = 16'hAAAA;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    chk("idle_after_done", {31'd0, busy}, 32'd0);

    // Back-to-back: each start issued in the done cycle of the previous op.
    start_op(16'h00F0, 16'h0010, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);
    wait_done();
    start_op(16'hC000, 16'h4000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    wait_done();
    start_op(16'h7000, 16'h1000, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    wait_done();
    @(negedge clk);
    chk("sum_holds", {15'd0, cout, ovf, sum}, {15'd0, 1'b0, 1'b1, 16'h8000});

    // Reset during the second RUN cycle abandons the op.
    start = 1'b1;
    a     = 16'h00FF;
    b     = 16'h0001;
    cin   = 1'b0;
    sub   = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midop_reset", {11'd0, busy, done, cout, ovf, sum}, 32'd0);
    repeat (6) @(negedge clk);
    chk("midop_no_done", {30'd0, busy, done}, 32'd0);

    // Reset and start together: reset wins.
    reset = 1'b1;
    start = 1'b1;
    a     = 16'h5555;
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    chk("reset_beats_start", {31'd0, busy}, 32'd0);

    op(16'h0010, 16'h0020, 1'b0, 1'b0, 16'h0030, 1'b0, 1'b0);

`ifdef SERIAL_ADDER_SUBTRACT_EN
    op(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    op(16'h1234, 16'h1234, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0);
    op(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
`endif

    repeat (3) @(negedge clk);
    chk("queue_drained", q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
